// File: rtl/stopwatch_pkg.sv
// Purpose: shared types and constants for the MM:SS stopwatch time base.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control).
package stopwatch_pkg;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    // Controller state, 2-bit encoding.
    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam int   DEF_MAX_MT = 5;
    localparam int   DEF_MAX_ST = 5;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// Purpose: one BCD counter digit with clear, increment and a programmable top value.
// Latency: value updates one cycle after inc/clear; carry_out is combinational from inc.
// Backpressure: none; every qualified inc is consumed the cycle it is presented.
//
// Ports: clk, rst_n (async active-low), clear (sync zero, beats inc), inc,
//        limit (top value, clamped to 9), value (digit), carry_out (inc at/over top).
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    input  logic [3:0] limit,
    output logic [3:0] value,
    output logic       carry_out
);

    bcd_t lim_eff;
    logic at_top;

    // A limit above 9 would let the digit leave BCD, so clamp it here.
    assign lim_eff = (limit > BCD_MAX) ? BCD_MAX : limit;

    // ">=" rather than "==" so an out-of-range value rolls to 0 on its next increment.
    assign at_top    = (value >= lim_eff);
    assign carry_out = inc && at_top && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= at_top ? '0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Purpose: MM:SS stopwatch time base (run/pause, clear, adjust) feeding a 4-digit display mux.
// Latency: one cycle from a qualifying tick/pulse to the registered digit and status outputs.
// Backpressure: none; ticks and pulses are sampled every cycle and never stalled.
//
// Ports: CLK, RST_N (async active-low), TICK_1HZ/TICK_2HZ (one-cycle ticks),
//        PAUSE/CLR (one-cycle pulses), ADJ/SEL (levels), MT/MO/ST/SO (BCD digits),
//        DISP_EN (blinks in adjust), RUNNING, WRAP (rollover pulse).
// Optional: define STOPWATCH_LAP_EN to add the LAP input (freeze displayed digits).
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MT = DEF_MAX_MT,
    parameter int MAX_ST = DEF_MAX_ST
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TICK_1HZ,
    input  logic       TICK_2HZ,
    input  logic       PAUSE,
    input  logic       CLR,
    input  logic       ADJ,
    input  logic       SEL,
`ifdef STOPWATCH_LAP_EN
    input  logic       LAP,
`endif
    output logic [3:0] MT,
    output logic [3:0] MO,
    output logic [3:0] ST,
    output logic [3:0] SO,
    output logic       DISP_EN,
    output logic       RUNNING,
    output logic       WRAP
);

    localparam bcd_t MT_LIM = bcd_t'(MAX_MT);
    localparam bcd_t ST_LIM = bcd_t'(MAX_ST);

    state_t state, next_state;
    logic   tick_run, adj_step, blink_tgl;
    logic   so_inc, st_inc, mo_inc, mt_inc;
    logic   so_c, st_c, mo_c, mt_c;
    bcd_t   so_q, st_q, mo_q, mt_q;

    // ADJ outranks PAUSE and ticks; CLR outranks everything and holds the state.
    assign tick_run  = (state == RUN) && TICK_1HZ && !CLR && !ADJ;
    assign adj_step  = (state == ADJUST) && ADJ && TICK_2HZ && !CLR;
    assign blink_tgl = (state == ADJUST) && ADJ && TICK_2HZ;

    // Seconds digits always chain; the seconds-to-minutes carry only exists while running,
    // so an adjust step never spills from one field into the other.
    assign so_inc = tick_run || (adj_step && !SEL);
    assign st_inc = so_c;
    assign mo_inc = (tick_run && st_c) || (adj_step && SEL);
    assign mt_inc = mo_c;

    bcd_digit u_so (.clk(CLK), .rst_n(RST_N), .clear(CLR), .inc(so_inc), .limit(BCD_MAX),
                    .value(so_q), .carry_out(so_c));
    bcd_digit u_st (.clk(CLK), .rst_n(RST_N), .clear(CLR), .inc(st_inc), .limit(ST_LIM),
                    .value(st_q), .carry_out(st_c));
    bcd_digit u_mo (.clk(CLK), .rst_n(RST_N), .clear(CLR), .inc(mo_inc), .limit(BCD_MAX),
                    .value(mo_q), .carry_out(mo_c));
    bcd_digit u_mt (.clk(CLK), .rst_n(RST_N), .clear(CLR), .inc(mt_inc), .limit(MT_LIM),
                    .value(mt_q), .carry_out(mt_c));

    always_comb begin
        next_state = state;
        if (!CLR) begin
            if (ADJ) begin
                next_state = ADJUST;
            end else begin
                case (state)
                    ADJUST:  next_state = PAUSED;
                    PAUSED:  next_state = PAUSE ? RUN : PAUSED;
                    RUN:     next_state = PAUSE ? PAUSED : RUN;
                    default: next_state = PAUSED;
                endcase
            end
        end
    end

    // DISP_EN doubles as the blink flop: it only toggles while staying in ADJUST.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= PAUSED;
            RUNNING <= 1'b0;
            DISP_EN <= 1'b1;
            WRAP    <= 1'b0;
        end else begin
            state   <= next_state;
            RUNNING <= (next_state == RUN);
            DISP_EN <= (next_state == ADJUST) ? (DISP_EN ^ blink_tgl) : 1'b1;
            WRAP    <= tick_run && mt_c;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic frozen;
    bcd_t lap_mt, lap_mo, lap_st, lap_so;

    // The snapshot is the count before any same-cycle tick, i.e. what is on display now.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frozen <= 1'b0;
            lap_mt <= '0;
            lap_mo <= '0;
            lap_st <= '0;
            lap_so <= '0;
        end else if (CLR || ADJ) begin
            frozen <= 1'b0;
        end else if (LAP) begin
            if (frozen) begin
                frozen <= 1'b0;
            end else if (state == RUN) begin
                frozen <= 1'b1;
                lap_mt <= mt_q;
                lap_mo <= mo_q;
                lap_st <= st_q;
                lap_so <= so_q;
            end
        end
    end

    assign MT = frozen ? lap_mt : mt_q;
    assign MO = frozen ? lap_mo : mo_q;
    assign ST = frozen ? lap_st : st_q;
    assign SO = frozen ? lap_so : so_q;
`else
    assign MT = mt_q;
    assign MO = mo_q;
    assign ST = st_q;
    assign SO = so_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

    localparam int MAX_MT = 5;
    localparam int MAX_ST = 5;
    localparam int SEC_PER_MIN = (MAX_ST + 1) * 10;
    localparam int MIN_MOD     = (MAX_MT + 1) * 10;
    localparam int M_PAUSED = 0, M_RUN = 1, M_ADJ = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       TICK_1HZ = 1'b0, TICK_2HZ = 1'b0, PAUSE = 1'b0, CLR = 1'b0;
    logic       ADJ = 1'b0, SEL = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic       LAP = 1'b0;
`endif
    logic [3:0] MT, MO, ST, SO;
    logic       DISP_EN, RUNNING, WRAP;

    int checks = 0;
    int failures = 0;
    int wrap_hi = 0;

    // Behavioural model: the count kept as plain minutes/seconds integers.
    int m_mode = M_PAUSED;
    int m_min = 0, m_sec = 0;
    int m_disp = 1, m_wrap = 0;
    int m_frozen = 0, m_snap_min = 0, m_snap_sec = 0;

    always #5 CLK = ~CLK;

    stopwatch_counter #(.MAX_MT(MAX_MT), .MAX_ST(MAX_ST)) dut (
        .CLK(CLK), .RST_N(RST_N), .TICK_1HZ(TICK_1HZ), .TICK_2HZ(TICK_2HZ),
        .PAUSE(PAUSE), .CLR(CLR), .ADJ(ADJ), .SEL(SEL),
`ifdef STOPWATCH_LAP_EN
        .LAP(LAP),
`endif
        .MT(MT), .MO(MO), .ST(ST), .SO(SO),
        .DISP_EN(DISP_EN), .RUNNING(RUNNING), .WRAP(WRAP)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int tot, nmode;
        bit run_tick, adj_step, tgl;
        m_wrap = 0;
        if (!RST_N) begin
            m_mode = M_PAUSED; m_min = 0; m_sec = 0; m_disp = 1; m_frozen = 0;
        end else begin
            run_tick = (m_mode == M_RUN) && TICK_1HZ && !CLR && !ADJ;
            adj_step = (m_mode == M_ADJ) && ADJ && TICK_2HZ && !CLR;
            tgl      = (m_mode == M_ADJ) && ADJ && TICK_2HZ;
`ifdef STOPWATCH_LAP_EN
            if (CLR || ADJ) m_frozen = 0;
            else if (LAP && m_frozen != 0) m_frozen = 0;
            else if (LAP && m_mode == M_RUN) begin
                m_frozen = 1; m_snap_min = m_min; m_snap_sec = m_sec;
            end
`endif
            if (CLR) begin
                m_min = 0; m_sec = 0;
            end else if (run_tick) begin
                tot = m_min * SEC_PER_MIN + m_sec + 1;
                if (tot == MIN_MOD * SEC_PER_MIN) begin
                    tot = 0; m_wrap = 1;
                end
                m_min = tot / SEC_PER_MIN;
                m_sec = tot % SEC_PER_MIN;
            end else if (adj_step) begin
                if (SEL) m_min = (m_min + 1) % MIN_MOD;
                else     m_sec = (m_sec + 1) % SEC_PER_MIN;
            end
            nmode = m_mode;
            if (!CLR) begin
                if (ADJ) nmode = M_ADJ;
                else if (m_mode == M_ADJ) nmode = M_PAUSED;
                else if (PAUSE) nmode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
            end
            m_disp = (nmode == M_ADJ) ? (m_disp ^ int'(tgl)) : 1;
            m_mode = nmode;
        end
    endtask

    task automatic compare_all();
        int dmin, dsec;
        dmin = (m_frozen != 0) ? m_snap_min : m_min;
        dsec = (m_frozen != 0) ? m_snap_sec : m_sec;
        chk("mdl_mt", MT, dmin / 10);
        chk("mdl_mo", MO, dmin % 10);
        chk("mdl_st", ST, dsec / 10);
        chk("mdl_so", SO, dsec % 10);
        chk("mdl_disp_en", DISP_EN, m_disp);
        chk("mdl_running", RUNNING, (m_mode == M_RUN) ? 1 : 0);
        chk("mdl_wrap", WRAP, m_wrap);
        wrap_hi += int'(WRAP);
    endtask

    // Inputs are driven just after a falling edge; the rising edge consumes them.
    task automatic cycle();
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            TICK_1HZ = 1'b1; cycle();
            TICK_1HZ = 1'b0; cycle();
        end
    endtask

    task automatic step2(input logic sel, input int n);
        SEL = sel;
        for (int i = 0; i < n; i++) begin
            TICK_2HZ = 1'b1; cycle();
            TICK_2HZ = 1'b0; cycle();
        end
    endtask

    task automatic pulse_pause();
        PAUSE = 1'b1; cycle();
        PAUSE = 1'b0; cycle();
    endtask

    function automatic int disp_time();
        return int'({MT, MO, ST, SO});
    endfunction

    initial begin
        @(negedge CLK);
        RST_N = 1'b0;
        cycle(); cycle();
        chk("reset_time", disp_time(), 'h0000);
        chk("reset_disp_en", DISP_EN, 1);
        chk("reset_running", RUNNING, 0);
        chk("reset_wrap", WRAP, 0);
        RST_N = 1'b1;
        cycle();

        // 61 seconds of running.
        pulse_pause();
        wrap_hi = 0;
        tick1(61);
        chk("run61_time", disp_time(), 'h0101);
        chk("run61_running", RUNNING, 1);
        chk("run61_no_wrap", wrap_hi, 0);

        // Preload 59:58, then roll over.
        ADJ = 1'b1; cycle();
        step2(1'b1, 58);
        step2(1'b0, 57);
        chk("preload_time", disp_time(), 'h5958);
        ADJ = 1'b0; cycle();
        chk("preload_exit_running", RUNNING, 0);
        pulse_pause();
        wrap_hi = 0;
        TICK_1HZ = 1'b1; cycle(); TICK_1HZ = 1'b0;
        chk("pre_wrap_time", disp_time(), 'h5959);
        chk("pre_wrap_wrap", WRAP, 0);
        cycle();
        TICK_1HZ = 1'b1; cycle(); TICK_1HZ = 1'b0;
        chk("wrap_time", disp_time(), 'h0000);
        chk("wrap_pulse", WRAP, 1);
        cycle();
        chk("wrap_one_cycle", WRAP, 0);
        chk("wrap_count", wrap_hi, 1);
        chk("wrap_keeps_running", RUNNING, 1);

        // Adjust: seconds field wraps without touching minutes, display blinks.
        ADJ = 1'b1; cycle();
        chk("adj_enter_disp", DISP_EN, 1);
        step2(1'b1, 3);
        step2(1'b0, 59);
        chk("adj_sec59_time", disp_time(), 'h0359);
        chk("adj_sec59_disp", DISP_EN, 1);
        step2(1'b0, 1);
        chk("adj_sec_wrap_time", disp_time(), 'h0300);
        chk("adj_sec_wrap_disp", DISP_EN, 0);
        ADJ = 1'b0; cycle();
        chk("adj_exit_disp", DISP_EN, 1);
        chk("adj_exit_running", RUNNING, 0);

        // CLR and tick together while running at 12:34.
        ADJ = 1'b1; cycle();
        step2(1'b1, 9);
        step2(1'b0, 34);
        ADJ = 1'b0; cycle();
        pulse_pause();
        chk("pre_clr_time", disp_time(), 'h1234);
        CLR = 1'b1; TICK_1HZ = 1'b1; cycle();
        CLR = 1'b0; TICK_1HZ = 1'b0;
        chk("clr_tick_time", disp_time(), 'h0000);
        chk("clr_tick_running", RUNNING, 1);
        chk("clr_tick_wrap", WRAP, 0);
        cycle();
        tick1(1);
        chk("after_clr_tick", disp_time(), 'h0001);

        // PAUSE and tick together while running at 00:09.
        tick1(8);
        chk("pre_pause_time", disp_time(), 'h0009);
        PAUSE = 1'b1; TICK_1HZ = 1'b1; cycle();
        PAUSE = 1'b0; TICK_1HZ = 1'b0;
        chk("pause_tick_time", disp_time(), 'h0010);
        chk("pause_tick_running", RUNNING, 0);
        tick1(3);
        chk("paused_hold_time", disp_time(), 'h0010);

        // Asynchronous reset mid-count takes effect before any clock edge.
        pulse_pause();
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_time", disp_time(), 'h0000);
        chk("async_reset_running", RUNNING, 0);
        chk("async_reset_disp", DISP_EN, 1);
        cycle();
        RST_N = 1'b1;
        cycle();

`ifdef STOPWATCH_LAP_EN
        pulse_pause();
        tick1(5);
        LAP = 1'b1; cycle(); LAP = 1'b0; cycle();
        tick1(3);
        chk("lap_frozen_time", disp_time(), 'h0005);
        chk("lap_running", RUNNING, 1);
        LAP = 1'b1; cycle(); LAP = 1'b0;
        chk("lap_release_time", disp_time(), 'h0008);
        cycle();
`endif

        // Randomised traffic, starting close to a rollover.
        ADJ = 1'b1; cycle();
        step2(1'b1, 59);
        step2(1'b0, 55);
        ADJ = 1'b0; cycle();
        pulse_pause();
        for (int i = 0; i < 4000; i++) begin
            TICK_1HZ = ($urandom_range(3) == 0);
            TICK_2HZ = ($urandom_range(2) == 0);
            PAUSE    = ($urandom_range(15) == 0);
            CLR      = ($urandom_range(149) == 0);
            SEL      = $urandom_range(1);
            if ($urandom_range(59) == 0) ADJ = ~ADJ;
`ifdef STOPWATCH_LAP_EN
            LAP      = ($urandom_range(29) == 0);
`endif
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Time-base side of the 4-digit 7-segment display interface.
- Counts elapsed time as 4 BCD digits MM:SS (MT, MO, ST, SO). Supports run/pause, clear and manual adjust modes.
- Outputs feed the display multiplexer's MT/MO/ST/SO inputs directly. DISP_EN feeds its EN input, so the display blinks during adjust.

Parameters:
- MAX_MT, 5, largest tens-of-minutes digit value; count wraps after MAX_MT9:59.
- MAX_ST, 5, largest tens-of-seconds digit value (5 gives 60 s per minute).

Ports:
- CLK  in  1  system clock; the only clock.
- RST_N  in  1  asynchronous active-low reset.
- TICK_1HZ  in  1  one-CLK-cycle pulse, 1 Hz; counting enable.
- TICK_2HZ  in  1  one-CLK-cycle pulse, 2 Hz; adjust stepping and blink rate.
- PAUSE  in  1  debounced one-cycle pulse; toggles run/pause.
- CLR  in  1  debounced one-cycle pulse; zeroes count.
- ADJ  in  1  level; 1 selects adjust mode.
- SEL  in  1  level; in adjust, 1 selects minutes field, 0 selects seconds field.
- MT  out  4  BCD tens of minutes.
- MO  out  4  BCD minutes ones.
- ST  out  4  BCD tens of seconds.
- SO  out  4  BCD seconds ones.
- DISP_EN  out  1  display enable: 1 normally, toggles in adjust.
- RUNNING  out  1  1 while in RUN state.
- WRAP  out  1  one-cycle pulse when count rolls over to 00:00.

Behaviour:
- Reset (RST_N low, async): state PAUSED; MT=MO=ST=SO=0; DISP_EN=1; RUNNING=0; WRAP=0; blink flop=1.
- All outputs are registered. A digit update is visible the cycle after the qualifying tick.
- States:
  - PAUSED: no counting.
  - RUN: counting on TICK_1HZ.
  - ADJUST: entered whenever ADJ=1, from any state.
- Transitions:
  - PAUSED + PAUSE -> RUN.
  - RUN + PAUSE -> PAUSED.
  - ADJ rising -> ADJUST.
  - ADJUST with ADJ=0 -> PAUSED; the clock never resumes automatically.
- RUN count on TICK_1HZ:
  - SO increments.
  - SO=9 -> SO=0 and carry into ST.
  - ST=MAX_ST with carry -> ST=0 and carry into MO.
  - MO=9 with carry -> MO=0 and carry into MT.
  - MT=MAX_MT with carry -> MT=0 and WRAP=1 for one cycle.
  - The count keeps running after a wrap.
- ADJUST on TICK_2HZ increments the selected field only, with no carry between fields:
  - seconds: 00..(MAX_ST)9, then 00.
  - minutes: 00..(MAX_MT)9, then 00.
  - WRAP is never asserted in ADJUST.
- DISP_EN:
  - In ADJUST, toggles on each TICK_2HZ.
  - Forced to 1 on leaving ADJUST and in all other states.
- Priority, highest first: CLR > ADJ > PAUSE > tick.
  - CLR zeroes all digits in any state; the state is unchanged except RUN stays RUN.
  - CLR and TICK_1HZ in the same cycle: result is 00:00 and no WRAP.
  - PAUSE is ignored while ADJ=1.
  - PAUSE and TICK_1HZ in the same cycle in RUN: the tick is counted, then the state goes PAUSED.
  - In PAUSED, the same-cycle tick is not counted.
- Digits never hold non-BCD values. An out-of-range value, which can only arise from an illegal parameter, is cleared to 0 on the next increment.
- Reset mid-count immediately returns to the reset state; no partial update is kept.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input LAP (1, one-cycle pulse).
  - In RUN, first LAP freezes the MT/MO/ST/SO outputs at the current count while the internal count continues. A second LAP releases them.
  - CLR, ADJ or reset also release the freeze.
  - RUNNING is unaffected.
  - WRAP still fires from the internal count.
- Undefined: no LAP port; outputs always equal the internal count.

Decomposition:
- Package stopwatch_pkg:
  - state enum PAUSED/RUN/ADJUST, 2-bit encoding;
  - bcd_t (4-bit) typedef;
  - constants BCD_MAX=9 and default limit values.
- Sub-module bcd_digit (one digit):
  - inputs: clk, reset, clear, inc, limit;
  - outputs: value, carry_out.
  - Instantiated four times.
  - Adjust mode drives inc per field with carry_out between fields masked.

Test Plan:
- Reset, PAUSE, 61 TICK_1HZ -> 01:01, RUNNING=1, WRAP never high.
- Preload to 59:58 via adjust, exit, PAUSE, 2 ticks -> 00:00, WRAP high exactly one cycle on second tick.
- ADJ=1, SEL=0, seconds at 59, one TICK_2HZ -> seconds 00, minutes unchanged; DISP_EN toggles each TICK_2HZ; ADJ=0 -> DISP_EN=1, state PAUSED.
- RUN at 12:34, CLR and TICK_1HZ same cycle -> 00:00, RUNNING=1, next tick -> 00:01.
- RUN at 00:09, PAUSE and TICK_1HZ same cycle -> 00:10, RUNNING=0; further ticks hold 00:10.
- STOPWATCH_LAP_EN: RUN at 00:05, LAP, 3 ticks -> outputs 00:05; LAP again -> 00:08.
